pe_array_seq: RTL

- Sequencer for a row of NUM_PE serial inner-product PEs computing one fully-connected layer.
- Reads a broadcast neuron from the neuron buffer and a NUM_PE-wide weight row from the weight buffer. Drives PE vld/ctrl (first/last element flags) and writes each batch of NUM_PE results to the output buffer.
- Sits between the layer-level controller (start/done) and the PE row plus its three on-chip buffers.

---
 rtl/pe_array_seq_pkg.sv | 22 ++
 rtl/pe_array_seq_if.sv | 34 +++
 rtl/pe_seq_addr_gen.sv | 63 ++++++
 rtl/pe_array_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pe_array_seq_pkg.sv
// rtl/pe_array_seq_pkg.sv - shared state encoding, ctrl bit positions and default widths
package pe_array_seq_pkg;

    localparam int DEF_NUM_PE  = 16;
    localparam int DEF_NI_W    = 12;
    localparam int DEF_NO_W    = 12;
    localparam int DEF_NADDR_W = 12;
    localparam int DEF_WADDR_W = 16;
    localparam int DEF_OADDR_W = 8;

    // pe_ctrl bit positions
    localparam int CTRL_FIRST = 0;
    localparam int CTRL_LAST  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/pe_array_seq_if.sv
// rtl/pe_array_seq_if.sv - buffer and PE-row signals between sequencer and datapath
interface pe_array_seq_if
    import pe_array_seq_pkg::*;
#(
    parameter int NUM_PE  = DEF_NUM_PE,
    parameter int NADDR_W = DEF_NADDR_W,
    parameter int WADDR_W = DEF_WADDR_W,
    parameter int OADDR_W = DEF_OADDR_W
) ();
    logic               nbuf_rd;
    logic [NADDR_W-1:0] nbuf_addr;
    logic               wbuf_rd;
    logic [WADDR_W-1:0] wbuf_addr;
    logic               pe_vld;
    logic [1:0]         pe_ctrl;
    logic               pe_vid;
    logic               out_wr;
    logic [OADDR_W-1:0] out_addr;
    logic [NUM_PE-1:0]  out_mask;

    modport master (
        output nbuf_rd, nbuf_addr, wbuf_rd, wbuf_addr,
        output pe_vld, pe_ctrl,
        output out_wr, out_addr, out_mask,
        input  pe_vid
    );

    modport slave (
        input  nbuf_rd, nbuf_addr, wbuf_rd, wbuf_addr,
        input  pe_vld, pe_ctrl,
        input  out_wr, out_addr, out_mask,
        output pe_vid
    );
endinterface

// File: rtl/pe_seq_addr_gen.sv
// rtl/pe_seq_addr_gen.sv - element/pass counters, running weight address and position flags
module pe_seq_addr_gen #(
    parameter int NI_W    = 12,
    parameter int NO_W    = 12,
    parameter int WADDR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               adv,
    input  logic [NI_W-1:0]    ni,
    input  logic [NO_W-1:0]    npass,
    output logic [NI_W-1:0]    i,
    output logic [NO_W-1:0]    p,
    output logic [WADDR_W-1:0] waddr,
    output logic               first,
    output logic               last_elem,
    output logic               last_pass
);
    logic [NI_W-1:0]    i_q, i_d;
    logic [NO_W-1:0]    p_q, p_d;
    logic [WADDR_W-1:0] waddr_q, waddr_d;

    assign i         = i_q;
    assign p         = p_q;
    assign waddr     = waddr_q;
    assign first     = (i_q == '0);
    assign last_elem = (i_q == ni - NI_W'(1));
    assign last_pass = (p_q == npass - NO_W'(1));

    // Weight rows are stored pass-major, so the weight address simply counts every issue.
    always_comb begin
        i_d     = i_q;
        p_d     = p_q;
        waddr_d = waddr_q;
        if (clear) begin
            i_d     = '0;
            p_d     = '0;
            waddr_d = '0;
        end else if (adv) begin
            waddr_d = waddr_q + WADDR_W'(1);
            if (last_elem) begin
                i_d = '0;
                p_d = p_q + NO_W'(1);
            end else begin
                i_d = i_q + NI_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q     <= '0;
            p_q     <= '0;
            waddr_q <= '0;
        end else begin
            i_q     <= i_d;
            p_q     <= p_d;
            waddr_q <= waddr_d;
        end
    end
endmodule

// File: rtl/pe_array_seq.sv
// rtl/pe_array_seq.sv - FC-layer sequencer for a row of serial inner-product PEs
module pe_array_seq
    import pe_array_seq_pkg::*;
#(
    parameter int NUM_PE  = DEF_NUM_PE,
    parameter int NI_W    = DEF_NI_W,
    parameter int NO_W    = DEF_NO_W,
    parameter int NADDR_W = DEF_NADDR_W,
    parameter int WADDR_W = DEF_WADDR_W,
    parameter int OADDR_W = DEF_OADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NI_W-1:0] cfg_ni,
    input  logic [NO_W-1:0] cfg_no,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    pe_array_seq_if.master  bus
);
    state_t              state_q;
    logic                busy_q, done_q, empty_q;
    logic [NI_W-1:0]     ni_q;
    logic [NO_W-1:0]     no_q;

    logic [NO_W-1:0]     npass, rem;
    logic [NUM_PE-1:0]   tail_mask;
    logic                issue, accept;
    logic [NI_W-1:0]     i;
    logic [NO_W-1:0]     p;
    logic [WADDR_W-1:0]  waddr;
    logic                first, last_elem, last_pass;

    // Two-stage align pipeline: stage 1 drives the PEs, stage 2 lines up with pe_vid.
    logic                vld_q, vld_d;
    logic [1:0]          ctrl_q, ctrl_d;
    logic [OADDR_W-1:0]  addr1_q, addr1_d, out_addr_q, out_addr_d;
    logic [NUM_PE-1:0]   mask1_q, mask1_d, out_mask_q, out_mask_d;
    logic                fin1_q, fin1_d, fin2_q, fin2_d;

    assign accept = (state_q == ST_IDLE) && start;
    assign issue  = (state_q == ST_RUN) && !empty_q && !stall;
    assign npass  = NO_W'((int'(no_q) + NUM_PE - 1) / NUM_PE);
    assign rem    = NO_W'(int'(no_q) % NUM_PE);

    pe_seq_addr_gen #(
        .NI_W    (NI_W),
        .NO_W    (NO_W),
        .WADDR_W (WADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .adv       (issue),
        .ni        (ni_q),
        .npass     (npass),
        .i         (i),
        .p         (p),
        .waddr     (waddr),
        .first     (first),
        .last_elem (last_elem),
        .last_pass (last_pass)
    );

    // Last-pass write mask: only the PEs that map to real output neurons
    always_comb begin
        tail_mask = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            tail_mask[k] = (rem == '0) || (NO_W'(k) < rem);
        end
    end

    // Issue-stage values entering the align pipeline; ctrl is forced low on idle cycles
    always_comb begin
        vld_d  = issue;
        ctrl_d = '0;
        if (issue) begin
            ctrl_d[CTRL_FIRST] = first;
            ctrl_d[CTRL_LAST]  = last_elem;
        end
        addr1_d    = OADDR_W'(p);
        mask1_d    = last_pass ? tail_mask : '1;
        fin1_d     = issue && last_elem && last_pass;
        out_addr_d = addr1_q;
        out_mask_d = mask1_q;
        fin2_d     = fin1_q;
    end

    // Align pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q      <= 1'b0;
            ctrl_q     <= '0;
            addr1_q    <= '0;
            mask1_q    <= '0;
            fin1_q     <= 1'b0;
            out_addr_q <= '0;
            out_mask_q <= '0;
            fin2_q     <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            ctrl_q     <= ctrl_d;
            addr1_q    <= addr1_d;
            mask1_q    <= mask1_d;
            fin1_q     <= fin1_d;
            out_addr_q <= out_addr_d;
            out_mask_q <= out_mask_d;
            fin2_q     <= fin2_d;
        end
    end

    // Layer FSM; an empty layer still passes through RUN so done timing is uniform
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            empty_q <= 1'b0;
            ni_q    <= '0;
            no_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ni_q    <= cfg_ni;
                        no_q    <= cfg_no;
                        empty_q <= (cfg_ni == '0) || (cfg_no == '0);
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (empty_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else if (issue && last_elem && last_pass) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Earlier passes may still write here (cfg_ni==1); wait for the final one.
                    if (bus.pe_vid && fin2_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.nbuf_rd   = issue;
    assign bus.wbuf_rd   = issue;
    assign bus.nbuf_addr = NADDR_W'(i);
    assign bus.wbuf_addr = waddr;
    assign bus.pe_vld    = vld_q;
    assign bus.pe_ctrl   = ctrl_q;
    assign bus.out_wr    = bus.pe_vid;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_mask  = out_mask_q;
endmodule
